// File: rtl/hier_merge_pkg.sv
// Shared constants and width helpers for the hierarchical merge array.
package hier_merge_pkg;

  localparam int unsigned DEF_NUM_CH = 2;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_BUS_W  = 2;
  localparam int unsigned DEF_CNT_W  = 16;

  // Channel-index width, never narrower than one bit.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hier_merge_array_if.sv
// Channel-side and merged-output handshake bundle of hier_merge_array.
interface hier_merge_array_if
  import hier_merge_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned BUS_W  = DEF_BUS_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
);
  localparam int unsigned CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [BUS_W-1:0]         cfg_bus;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic [CNT_W-1:0]         xfer_cnt;

  modport master (
    output in_valid, in_data, cfg_bus, out_ready,
    input  in_ready, out_valid, out_data, out_ch, xfer_cnt
  );

  modport slave (
    input  in_valid, in_data, cfg_bus, out_ready,
    output in_ready, out_valid, out_data, out_ch, xfer_cnt
  );
endinterface

// File: rtl/merge_stage.sv
// One-entry channel buffer storing payload plus the broadcast offset.
module merge_stage
  import hier_merge_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned BUS_W  = DEF_BUS_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [BUS_W-1:0]  cfg_i,
  input  logic              drain_i,
  output logic              ready_c_o,
  output logic              full_o,
  output logic [DATA_W-1:0] data_o
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              accept_c;

  // Draining and refilling in the same cycle keeps the slot occupied.
  assign ready_c_o = ~reset & (~full_q | drain_i);
  assign accept_c  = in_valid_i & ready_c_o;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (drain_i) full_d = 1'b0;
    if (accept_c) begin
      full_d = 1'b1;
      data_d = in_data_i + DATA_W'(cfg_i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/hier_merge_array.sv
// Merges NUM_CH buffered channels onto one output with round-robin arbitration.
module hier_merge_array
  import hier_merge_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned BUS_W  = DEF_BUS_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  hier_merge_array_if.slave bus
);

  localparam int unsigned CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] ready_c;
  logic [NUM_CH-1:0] drain_c;
  logic [DATA_W-1:0] stage_data [NUM_CH];

  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
  logic              lock_q, lock_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   rr_grant_c, grant_c;
  logic              out_valid_c, xfer_c;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    merge_stage #(.DATA_W(DATA_W), .BUS_W(BUS_W)) u_stage (
      .clk       (clk),
      .reset     (reset),
      .in_valid_i(bus.in_valid[i]),
      .in_data_i (bus.in_data[i*DATA_W +: DATA_W]),
      .cfg_i     (bus.cfg_bus),
      .drain_i   (drain_c[i]),
      .ready_c_o (ready_c[i]),
      .full_o    (full[i]),
      .data_o    (stage_data[i])
    );
  end

  // Scan from the farthest wrapped index down so the nearest full channel wins.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    rr_grant_c = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = 32'(rr_ptr_q) + (NUM_CH - 1 - k);
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (full[CH_W'(idx)]) rr_grant_c = CH_W'(idx);
    end
  end

  assign grant_c     = lock_q ? lock_ch_q : rr_grant_c;
  assign out_valid_c = ~reset & (|full);
  assign xfer_c      = out_valid_c & bus.out_ready;

  always_comb begin
    drain_c = '0;
    for (int i = 0; i < NUM_CH; i++) drain_c[i] = xfer_c & (grant_c == CH_W'(i));
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_valid_c ? stage_data[grant_c] : '0;
  assign bus.out_ch    = out_valid_c ? grant_c : '0;
  assign bus.xfer_cnt  = cnt_q;

  // A stalled output pins the grant so data and index stay stable.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    lock_d    = out_valid_c & ~bus.out_ready;
    lock_ch_d = grant_c;
    if (xfer_c) begin
      rr_ptr_d = (grant_c == CH_W'(NUM_CH - 1)) ? '0 : grant_c + CH_W'(1);
      cnt_d    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      cnt_q     <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hier_merge_array.sv
// Directed and random checks of hier_merge_array against a cycle-level reference model.
module tb_hier_merge_array;

  localparam int unsigned NCH = 2;
  localparam int unsigned DW  = 8;
  localparam int unsigned BW  = 2;
  localparam int unsigned CW  = 16;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  hier_merge_array_if #(.NUM_CH(NCH), .DATA_W(DW), .BUS_W(BW), .CNT_W(CW)) bus ();

  hier_merge_array #(.NUM_CH(NCH), .DATA_W(DW), .BUS_W(BW), .CNT_W(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: what each channel holds, whose turn it is, and any pinned grant.
  bit       m_full [NCH];
  int       m_val  [NCH];
  int       m_rr;
  bit       m_lock;
  int       m_lock_ch;
  int       m_cnt;
  bit       m_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_grant();
    if (m_lock) return m_lock_ch;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (m_rr + k) % NCH;
      if (m_full[c]) return c;
    end
    return 0;
  endfunction

  task automatic cyc(input logic r, input logic [1:0] v, input logic [7:0] d0,
                     input logic [7:0] d1, input logic [1:0] cfg, input logic ordy);
    int        g;
    bit        any;
    bit        xfer;
    logic [1:0] erdy;
    int        din [NCH];
    reset        = r;
    bus.in_valid = v;
    bus.in_data  = {d1, d0};
    bus.cfg_bus  = cfg;
    bus.out_ready = ordy;
    din[0] = int'(d0);
    din[1] = int'(d1);
    #1;
    any = 1'b0;
    for (int i = 0; i < NCH; i++) any |= m_full[i];
    g = ref_grant();
    if (r) begin
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
      if (m_known) chk("rst_xfer_cnt", 32'(bus.xfer_cnt), 32'(m_cnt));
      for (int i = 0; i < NCH; i++) begin
        m_full[i] = 1'b0;
        m_val[i]  = 0;
      end
      m_rr = 0; m_lock = 1'b0; m_lock_ch = 0; m_cnt = 0; m_known = 1'b1;
    end else begin
      xfer = any & ordy;
      for (int i = 0; i < NCH; i++) erdy[i] = !m_full[i] || (xfer && g == i);
      chk("out_valid", 32'(bus.out_valid), 32'(any));
      chk("out_data", 32'(bus.out_data), any ? 32'(m_val[g]) : 32'd0);
      chk("out_ch", 32'(bus.out_ch), any ? 32'(g) : 32'd0);
      chk("in_ready", 32'(bus.in_ready), 32'(erdy));
      chk("xfer_cnt", 32'(bus.xfer_cnt), 32'(m_cnt));
      if (xfer) begin
        m_full[g] = 1'b0;
        m_rr      = (g + 1) % NCH;
        if (m_cnt < 65535) m_cnt++;
      end
      for (int i = 0; i < NCH; i++)
        if (v[i] && erdy[i]) begin
          m_full[i] = 1'b1;
          m_val[i]  = (din[i] + int'(cfg)) % 256;
        end
      m_lock    = any & !ordy;
      m_lock_ch = g;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_known = 1'b0;
    m_rr = 0; m_lock = 1'b0; m_lock_ch = 0; m_cnt = 0;
    for (int i = 0; i < NCH; i++) begin
      m_full[i] = 1'b0;
      m_val[i]  = 0;
    end
    reset = 1'b1;
    bus.in_valid = '0; bus.in_data = '0; bus.cfg_bus = '0; bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, 2'b00, 8'h00, 8'h00, 2'b00, 1);
    cyc(1, 2'b11, 8'h55, 8'hAA, 2'b01, 1);

    // Single payload with offset, one-cycle latency.
    cyc(0, 2'b01, 8'h10, 8'h00, 2'b11, 1);
    chk("first_data", 32'(bus.out_data), 32'h13);
    chk("first_ch", 32'(bus.out_ch), 32'd0);
    cyc(0, 2'b00, 8'h00, 8'h00, 2'b00, 1);
    chk("first_cnt", 32'(bus.xfer_cnt), 32'd1);
    cyc(0, 2'b00, 8'h00, 8'h00, 2'b00, 1);

    // Round-robin fairness over two rounds.
    cyc(1, 2'b00, 8'h00, 8'h00, 2'b00, 1);
    cyc(0, 2'b11, 8'h01, 8'h02, 2'b00, 1);
    for (int k = 0; k < 4; k++) cyc(0, 2'b00, 8'h00, 8'h00, 2'b00, 1);
    cyc(0, 2'b11, 8'h03, 8'h04, 2'b00, 1);
    chk("rr_refill_ch", 32'(bus.out_ch), 32'd0);
    for (int k = 0; k < 4; k++) cyc(0, 2'b00, 8'h00, 8'h00, 2'b00, 1);

    // Stall with ch1 granted while ch0 fills.
    cyc(0, 2'b10, 8'h00, 8'h77, 2'b01, 0);
    for (int k = 0; k < 5; k++) cyc(0, 2'b01, 8'h20 + 8'(k), 8'h00, 2'b10, 0);
    chk("stall_ch", 32'(bus.out_ch), 32'd1);
    chk("stall_data", 32'(bus.out_data), 32'h78);
    for (int k = 0; k < 3; k++) cyc(0, 2'b00, 8'h00, 8'h00, 2'b00, 1);

    // Offset add wraps modulo 2^DATA_W.
    cyc(0, 2'b01, 8'hFF, 8'h00, 2'b10, 0);
    chk("wrap_data", 32'(bus.out_data), 32'h01);
    cyc(0, 2'b00, 8'h00, 8'h00, 2'b00, 1);

    // Back-to-back stream on ch0.
    for (int k = 0; k < 8; k++) cyc(0, 2'b01, 8'(k * 3), 8'h00, 2'(k), 1);
    cyc(0, 2'b00, 8'h00, 8'h00, 2'b00, 1);

    // Reset with both buffers full discards them.
    cyc(0, 2'b11, 8'h11, 8'h22, 2'b00, 0);
    cyc(1, 2'b00, 8'h00, 8'h00, 2'b00, 0);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    for (int k = 0; k < 3; k++) cyc(0, 2'b00, 8'h00, 8'h00, 2'b00, 1);

    // Random traffic with occasional reset.
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
          2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
          2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
